// File: rtl/nes_attr_lookup_if.sv
// Attribute-table lookup bus: PPU writes, mirroring select, clear and palette lookups.
// The master drives requests and writes; the slave returns palette bits and status.
interface nes_attr_lookup_if;
    logic [1:0]  mirror;
    logic        clr;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_req;
    logic [5:0]  rd_tile_x;
    logic [5:0]  rd_tile_y;
    logic        rd_rdy;
    logic        rd_valid;
    logic [1:0]  rd_pal;
    logic        busy;

    modport master (
        output mirror, clr, wr_en, wr_addr, wr_data,
        output rd_req, rd_tile_x, rd_tile_y,
        input  rd_rdy, rd_valid, rd_pal, busy
    );

    modport slave (
        input  mirror, clr, wr_en, wr_addr, wr_data,
        input  rd_req, rd_tile_x, rd_tile_y,
        output rd_rdy, rd_valid, rd_pal, busy
    );
endinterface

// File: rtl/nes_attr_lookup.sv
// NES attribute-table store with nametable mirroring and a 2-cycle palette lookup.
// A CLEAR/RUN FSM initialises every byte after reset or on a clr pulse.
module nes_attr_lookup #(
    parameter int          NUM_NT   = 2,
    parameter logic [7:0]  INIT_VAL = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    nes_attr_lookup_if.slave bus
);
    localparam int DEPTH = 64 * NUM_NT;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t       state;
    logic [AW-1:0] cnt;

    logic [7:0]   mem [DEPTH];
    logic [7:0]   rdata;

    // Truncating {P,byte} to AW bits applies the modulo-NUM_NT fold.
    function automatic logic [AW-1:0] phys_addr(
        input logic [1:0] l,
        input logic [1:0] m,
        input logic [5:0] b
    );
        logic [1:0] p;
        logic [7:0] full;
        p = 2'd0;
        if (NUM_NT == 4) begin
            p = l;
        end else begin
            unique case (m)
                2'b00:   p = {1'b0, l[1]};
                2'b01:   p = {1'b0, l[0]};
                2'b10:   p = 2'd0;
                default: p = 2'd1;
            endcase
            if (NUM_NT == 1) p = 2'd0;
        end
        full = {p, b};
        return full[AW-1:0];
    endfunction

    logic          run;
    logic          accept;
    logic          oob;
    logic          hi;
    logic [5:0]    row;
    logic [5:0]    rbyte;
    logic [1:0]    rsel;
    logic [AW-1:0] raddr;

    assign run    = (state == RUN);
    assign accept = bus.rd_req && run;
    assign oob    = bus.rd_tile_y >= 6'd60;
    assign hi     = bus.rd_tile_y >= 6'd30;
    assign row    = hi ? bus.rd_tile_y - 6'd30 : bus.rd_tile_y;
    assign rbyte  = {row[4:2], bus.rd_tile_x[4:2]};
    assign rsel   = {row[1], bus.rd_tile_x[1]};
    assign raddr  = phys_addr({hi, bus.rd_tile_x[5]}, bus.mirror, rbyte);

    logic          wr_ok;
    logic [AW-1:0] waddr;
    logic          we;
    logic [AW-1:0] wa;
    logic [7:0]    wd;

    assign wr_ok = run && bus.wr_en && (bus.wr_addr[9:6] == 4'hF);
    assign waddr = phys_addr(bus.wr_addr[11:10], bus.mirror,
                             bus.wr_addr[5:0]);
    assign we    = rst_n && ((state == CLEAR) || wr_ok);
    assign wa    = (state == CLEAR) ? cnt : waddr;
    assign wd    = (state == CLEAR) ? INIT_VAL : bus.wr_data;

    // Registered read sees the pre-write value on a same-edge collision.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rdata <= mem[raddr];
    end

    logic       v1;
    logic [1:0] sel1;
    logic       oob1;
    logic [7:0] shifted;
    logic       valid_q;
    logic [1:0] pal_q;

    assign shifted = rdata >> {sel1, 1'b0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            cnt     <= '0;
            v1      <= 1'b0;
            sel1    <= 2'd0;
            oob1    <= 1'b0;
            valid_q <= 1'b0;
            pal_q   <= 2'd0;
        end else begin
            v1      <= accept;
            sel1    <= rsel;
            oob1    <= oob;
            valid_q <= v1;
            if (v1) pal_q <= oob1 ? 2'd0 : shifted[1:0];
            unique case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) state <= RUN;
                end
                RUN: begin
                    if (bus.clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign bus.rd_rdy   = run;
    assign bus.busy     = (state == CLEAR);
    assign bus.rd_valid = valid_q;
    assign bus.rd_pal   = pal_q;
endmodule
